// File: rtl/cbus_rr_arbiter_if.sv
// cbus_rr_arbiter_if: groups the arbiter's upstream request/response arrays and its
// single downstream link; master = requester/target side, slave = arbiter side.
interface cbus_rr_arbiter_if #(
    parameter int  NUM_INPUTS = 2,
    parameter type req_t      = logic,
    parameter type resp_t     = logic
);
    req_t  ireqs  [NUM_INPUTS];
    resp_t iresps [NUM_INPUTS];
    req_t  oreq;
    resp_t oresp;

    modport master (output ireqs, input iresps, input oreq, output oresp);
    modport slave  (input ireqs, output iresps, output oreq, input oresp);
endinterface

// File: rtl/cbus_rr_arbiter.sv
// cbus_rr_arbiter: shares one downstream cbus among NUM_INPUTS masters, one transaction at a time.
// Define CBUS_ARB_ROUND_ROBIN_EN for round-robin selection; default build is fixed priority.
package cbus_pkg;
    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [7:0]  len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;
endpackage

module cbus_rr_arbiter
    import cbus_pkg::*;
#(
    parameter int  NUM_INPUTS = 2,
    parameter type req_t      = cbus_req_t,
    parameter type resp_t     = cbus_resp_t
) (
    input  logic  clk,
    input  logic  resetn,
    input  req_t  ireqs  [NUM_INPUTS],
    output resp_t iresps [NUM_INPUTS],
    output req_t  oreq,
    input  resp_t oresp
);
    localparam int IDX_W = $clog2(NUM_INPUTS);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] cand;
    logic             any_valid;
`ifdef CBUS_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_inc;

    assign idx_inc = (idx_q == IDX_W'(NUM_INPUTS - 1)) ? '0 : idx_q + 1'b1;
`endif

    // Scan from the highest search position down so the first eligible candidate wins.
    always_comb begin
        any_valid = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
`ifdef CBUS_ARB_ROUND_ROBIN_EN
            cand = IDX_W'((int'(ptr_q) + k) % NUM_INPUTS);
`else
            cand = IDX_W'(k);
`endif
            if (ireqs[cand].valid) begin
                any_valid = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        oreq    = '0;
        iresps  = '{default: '0};
`ifdef CBUS_ARB_ROUND_ROBIN_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    idx_d   = sel_idx;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // Grant is held even if the owner drops valid; only ready&last releases it.
                oreq          = ireqs[idx_q];
                iresps[idx_q] = oresp;
                if (oresp.ready && oresp.last) begin
                    state_d = IDLE;
`ifdef CBUS_ARB_ROUND_ROBIN_EN
                    ptr_d   = idx_inc;
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            idx_q   <= '0;
`ifdef CBUS_ARB_ROUND_ROBIN_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
`ifdef CBUS_ARB_ROUND_ROBIN_EN
            ptr_q   <= ptr_d;
`endif
        end
    end
endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// tb_cbus_rr_arbiter: directed and randomized checks of cbus_rr_arbiter (NUM_INPUTS=3)
// against a transaction-level owner/pointer model of the arbitration rules.
module tb_cbus_rr_arbiter;
    import cbus_pkg::*;

    localparam int N   = 3;
    localparam int RQW = $bits(cbus_req_t);
    localparam int RSW = $bits(cbus_resp_t);
    localparam int OW  = RQW + N * RSW;

    localparam logic [31:0] A0 = 32'h2000_0040;
    localparam logic [31:0] A1 = 32'h3000_0080;
    localparam logic [31:0] A2 = 32'h4000_0100;

    logic clk;
    logic resetn;
    int   vectors;
    int   miscompares;
    int   m_owner;   // -1 when no master holds the bus
    int   m_ptr;

    cbus_rr_arbiter_if #(.NUM_INPUTS(N), .req_t(cbus_req_t), .resp_t(cbus_resp_t)) bus ();

    cbus_rr_arbiter #(.NUM_INPUTS(N), .req_t(cbus_req_t), .resp_t(cbus_resp_t)) dut (
        .clk    (clk),
        .resetn (resetn),
        .ireqs  (bus.ireqs),
        .iresps (bus.iresps),
        .oreq   (bus.oreq),
        .oresp  (bus.oresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic cbus_req_t mk_req(logic v, logic [31:0] addr, logic [7:0] len);
        cbus_req_t r;
        r          = '0;
        r.valid    = v;
        r.size     = 2'd2;
        r.addr     = addr;
        r.wdata    = $urandom;
        r.wstrb    = 4'hf;
        r.len      = len;
        return r;
    endfunction

    function automatic cbus_resp_t mk_resp(logic rdy, logic lst);
        cbus_resp_t r;
        r.ready = rdy;
        r.last  = lst;
        r.data  = $urandom;
        return r;
    endfunction

    task automatic idle_inputs();
        for (int i = 0; i < N; i++) bus.ireqs[i] = '0;
        bus.oresp = '0;
    endtask

    // Model: selection order derived from the policy, not from any hardware structure.
    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            int j;
`ifdef CBUS_ARB_ROUND_ROBIN_EN
            j = (m_ptr + k) % N;
`else
            j = k;
`endif
            if (bus.ireqs[j].valid) return j;
        end
        return -1;
    endfunction

    function automatic logic [OW-1:0] exp_vec();
        logic [OW-1:0] v;
        v = '0;
        if (m_owner >= 0) begin
            v[OW-1 -: RQW]            = bus.ireqs[m_owner];
            v[m_owner*RSW +: RSW]     = bus.oresp;
        end
        return v;
    endfunction

    function automatic logic [OW-1:0] obs_vec();
        logic [OW-1:0] v;
        v[OW-1 -: RQW] = bus.oreq;
        for (int i = 0; i < N; i++) v[i*RSW +: RSW] = bus.iresps[i];
        return v;
    endfunction

    // Advance one clock: model next state from pre-edge inputs, commit after the edge.
    task automatic clock();
        int nxt_owner;
        int nxt_ptr;
        nxt_owner = m_owner;
        nxt_ptr   = m_ptr;
        if (!resetn) begin
            nxt_owner = -1;
            nxt_ptr   = 0;
        end else if (m_owner < 0) begin
            nxt_owner = pick();
        end else if (bus.oresp.ready && bus.oresp.last) begin
            nxt_ptr   = (m_owner + 1) % N;
            nxt_owner = -1;
        end
        @(posedge clk);
        m_owner = nxt_owner;
        m_ptr   = nxt_ptr;
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.ireqs[0] = mk_req(1'b1, A0, 8'd0);
        bus.oresp    = mk_resp(1'b1, 1'b1);
        #2 resetn = 1'b0;
        m_owner = -1;
        m_ptr   = 0;
        #1;
        vectors++;
        if (bus.oreq !== '0) begin
            miscompares++;
            $display("FAIL reset_oreq: got %h want 0", bus.oreq);
        end
        for (int i = 0; i < N; i++) begin
            vectors++;
            if (bus.iresps[i] !== '0) begin
                miscompares++;
                $display("FAIL reset_iresp%0d: got %h want 0", i, bus.iresps[i]);
            end
        end
        clock();
        clock();
        #1;
        vectors++;
        if (bus.oreq !== '0) begin
            miscompares++;
            $display("FAIL reset_held_oreq: got %h want 0", bus.oreq);
        end
        resetn    = 1'b1;
        bus.oresp = '0;
        #1;
        vectors++;
        if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL reset_release_idle: got %h want %h", obs_vec(), exp_vec());
        end
        clock();
        #1;
        vectors++;
        if (bus.oreq.addr !== A0 || bus.oreq.valid !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_first_grant: got addr %h valid %b want addr %h valid 1",
                     bus.oreq.addr, bus.oreq.valid, A0);
        end
        bus.oresp = mk_resp(1'b1, 1'b1);
        #1;
        vectors++;
        if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL reset_first_done: got %h want %h", obs_vec(), exp_vec());
        end
        clock();
        idle_inputs();
        clock();
    endtask

    task automatic test_single_master();
        cbus_resp_t rsp;
        idle_inputs();
        bus.ireqs[1] = mk_req(1'b1, 32'h1fc0_0000, 8'd0);
        #1;
        vectors++;
        if (bus.oreq !== '0) begin
            miscompares++;
            $display("FAIL single_idle: got %h want 0", bus.oreq);
        end
        clock();
        for (int b = 1; b <= 3; b++) begin
            rsp       = (b == 3) ? mk_resp(1'b1, 1'b1) : '0;
            bus.oresp = rsp;
            #1;
            vectors++;
            if (bus.oreq.addr !== 32'h1fc0_0000 || bus.oreq.valid !== 1'b1) begin
                miscompares++;
                $display("FAIL single_grant beat %0d: got addr %h valid %b want 1fc00000 1",
                         b, bus.oreq.addr, bus.oreq.valid);
            end
            vectors++;
            if (bus.iresps[1] !== rsp || bus.iresps[0] !== '0) begin
                miscompares++;
                $display("FAIL single_resp beat %0d: got %h/%h want %h/0",
                         b, bus.iresps[1], bus.iresps[0], rsp);
            end
            clock();
        end
        #1;
        vectors++;
        if (bus.oreq !== '0 || bus.iresps[1] !== '0) begin
            miscompares++;
            $display("FAIL single_back_idle: got %h/%h want 0/0", bus.oreq, bus.iresps[1]);
        end
        idle_inputs();
        clock();
    endtask

    task automatic test_burst();
        cbus_resp_t rsp;
        idle_inputs();
        bus.ireqs[0] = mk_req(1'b1, A0, 8'd3);
        bus.ireqs[1] = mk_req(1'b1, A1, 8'd0);
        #1;
        vectors++;
        if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL burst_idle: got %h want %h", obs_vec(), exp_vec());
        end
        clock();
        for (int b = 1; b <= 4; b++) begin
            rsp       = mk_resp(1'b1, b == 4);
            bus.oresp = rsp;
            #1;
            vectors++;
            if (bus.oreq.addr !== A0 || bus.iresps[0].data !== rsp.data || bus.iresps[1] !== '0) begin
                miscompares++;
                $display("FAIL burst_beat %0d: got addr %h data %h want addr %h data %h",
                         b, bus.oreq.addr, bus.iresps[0].data, A0, rsp.data);
            end
            clock();
        end
        bus.ireqs[0] = '0;
        bus.oresp    = '0;
        #1;
        vectors++;
        if (bus.oreq !== '0) begin
            miscompares++;
            $display("FAIL burst_gap: got %h want 0", bus.oreq);
        end
        clock();
        #1;
        vectors++;
        if (bus.oreq.addr !== A1) begin
            miscompares++;
            $display("FAIL burst_pending_grant: got addr %h want %h", bus.oreq.addr, A1);
        end
        bus.oresp = mk_resp(1'b1, 1'b1);
        clock();
        idle_inputs();
        clock();
    endtask

    task automatic test_contention();
        logic [31:0] exp_addr;
        idle_inputs();
        bus.ireqs[0] = mk_req(1'b1, A0, 8'd0);
        bus.ireqs[1] = mk_req(1'b1, A1, 8'd0);
        for (int t = 0; t < 4; t++) begin
            bus.oresp = '0;
            #1;
            vectors++;
            if (bus.oreq !== '0) begin
                miscompares++;
                $display("FAIL contention_idle %0d: got %h want 0", t, bus.oreq);
            end
            clock();
`ifdef CBUS_ARB_ROUND_ROBIN_EN
            exp_addr = (t % 2 == 0) ? A0 : A1;
`else
            exp_addr = A0;
`endif
            #1;
            vectors++;
            if (bus.oreq.addr !== exp_addr) begin
                miscompares++;
                $display("FAIL contention_grant %0d: got addr %h want %h", t, bus.oreq.addr, exp_addr);
            end
            clock();
            bus.oresp = mk_resp(1'b1, 1'b1);
            #1;
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL contention_done %0d: got %h want %h", t, obs_vec(), exp_vec());
            end
            clock();
        end
        idle_inputs();
        clock();
    endtask

    task automatic test_protocol_violation();
        idle_inputs();
        bus.ireqs[2] = mk_req(1'b1, A2, 8'd3);
        #1;
        clock();
        bus.ireqs[2].valid = 1'b0;
        bus.ireqs[0]       = mk_req(1'b1, A0, 8'd0);
        for (int c = 0; c < 2; c++) begin
            bus.oresp = mk_resp(1'b0, 1'($urandom_range(0, 1)));
            #1;
            vectors++;
            if (bus.oreq.valid !== 1'b0 || bus.oreq.addr !== A2 || bus.iresps[2] !== bus.oresp) begin
                miscompares++;
                $display("FAIL dropped_valid %0d: got valid %b addr %h resp %h want 0 %h %h",
                         c, bus.oreq.valid, bus.oreq.addr, bus.iresps[2], A2, bus.oresp);
            end
            clock();
        end
        bus.oresp = mk_resp(1'b1, 1'b1);
        #1;
        vectors++;
        if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL dropped_done: got %h want %h", obs_vec(), exp_vec());
        end
        clock();
        bus.ireqs[1] = mk_req(1'b1, A1, 8'd0);
        bus.ireqs[2] = mk_req(1'b1, A2, 8'd0);
        bus.oresp    = '0;
        #1;
        clock();
        #1;
        vectors++;
        if (bus.oreq.addr !== A0) begin
            miscompares++;
            $display("FAIL wrap_grant: got addr %h want %h", bus.oreq.addr, A0);
        end
        bus.oresp = mk_resp(1'b1, 1'b1);
        clock();
        idle_inputs();
        clock();
    endtask

    task automatic test_reset_mid_burst();
        idle_inputs();
        bus.ireqs[1] = mk_req(1'b1, A1, 8'd3);
        #1;
        clock();
        bus.oresp = mk_resp(1'b1, 1'b0);
        clock();
        bus.oresp = mk_resp(1'b1, 1'b0);
        #1;
        vectors++;
        if (bus.oreq.addr !== A1 || bus.iresps[1] !== bus.oresp) begin
            miscompares++;
            $display("FAIL midburst_beat2: got addr %h resp %h want %h %h",
                     bus.oreq.addr, bus.iresps[1], A1, bus.oresp);
        end
        #2 resetn = 1'b0;
        m_owner = -1;
        m_ptr   = 0;
        #1;
        vectors++;
        if (bus.oreq !== '0 || bus.iresps[1] !== '0) begin
            miscompares++;
            $display("FAIL midburst_async_clear: got %h/%h want 0/0", bus.oreq, bus.iresps[1]);
        end
        clock();
        resetn       = 1'b1;
        bus.ireqs[0] = mk_req(1'b1, A0, 8'd0);
        bus.oresp    = '0;
        #1;
        vectors++;
        if (bus.oreq !== '0) begin
            miscompares++;
            $display("FAIL midburst_no_replay: got %h want 0", bus.oreq);
        end
        clock();
        #1;
        vectors++;
        if (bus.oreq.addr !== A0) begin
            miscompares++;
            $display("FAIL midburst_restart: got addr %h want %h", bus.oreq.addr, A0);
        end
        bus.oresp = mk_resp(1'b1, 1'b1);
        clock();
        idle_inputs();
        clock();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                bus.ireqs[i] = mk_req(1'($urandom_range(0, 1)),
                                      32'h1000_0000 * (i + 1) + ($urandom & 32'h00ff_fffc),
                                      8'($urandom_range(0, 3)));
            end
            bus.oresp = mk_resp(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 49) == 0) begin
                resetn  = 1'b0;
                m_owner = -1;
                m_ptr   = 0;
            end else begin
                resetn = 1'b1;
            end
            #1;
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL random cyc %0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            clock();
        end
        resetn = 1'b1;
        idle_inputs();
        bus.oresp = mk_resp(1'b1, 1'b1);
        clock();
        idle_inputs();
        #1;
        vectors++;
        if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL random_drain: got %h want %h", obs_vec(), exp_vec());
        end
        clock();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        m_owner     = -1;
        m_ptr       = 0;
        resetn      = 1'b1;
        for (int i = 0; i < N; i++) bus.ireqs[i] = '0;
        bus.oresp = '0;
        test_reset();
        test_single_master();
        test_burst();
        test_contention();
        test_protocol_violation();
        test_reset_mid_burst();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/cbus_rr_arbiter.md
CBUS_RR_ARBITER -- requirements
Module: cbus_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 2, number of cbus requesters sharing one cbus (legal range 2..8).
REQ-002 SHALL have parameter type req_t, default cbus_req_t, request bundle type.
REQ-003 SHALL have parameter type resp_t, default cbus_resp_t, response bundle type.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-006 SHALL have port ireqs  input  req_t[NUM_INPUTS]  requests from upstream masters (I-cache, D-cache, uncached path).
REQ-007 SHALL have port iresps  output  resp_t[NUM_INPUTS]  responses routed back to each master.
REQ-008 SHALL have port oreq  output  req_t  single downstream request, fed to the address-translation stage.
REQ-009 SHALL have port oresp  input  resp_t  downstream response (ready, last, data).

Function
REQ-010 SHALL implement FSM with states IDLE and BUSY, plus registered grant index idx of width $clog2(NUM_INPUTS).
REQ-011 In IDLE, oreq SHALL be all-zero and every iresps[i] SHALL be all-zero.
REQ-012 In IDLE, if any ireqs[i].valid is 1, SHALL latch the selected index into idx and enter BUSY on the next edge; arbitration latency exactly one cycle.
REQ-013 In IDLE with no valid request, SHALL stay in IDLE with idx unchanged.
REQ-014 In BUSY, oreq SHALL equal ireqs[idx] combinationally; iresps[idx] SHALL equal oresp; all other iresps SHALL be all-zero.
REQ-015 In BUSY, grant SHALL be held (no re-arbitration) until a cycle where oresp.ready=1 and oresp.last=1; on that edge SHALL return to IDLE.
REQ-016 Multi-beat bursts (len>0) SHALL stay granted across all beats; ready with last=0 SHALL NOT end the grant.
REQ-017 A new request arriving from any master during BUSY SHALL wait; it is eligible in the IDLE cycle after completion (minimum one idle cycle between transactions).
REQ-018 A granted master dropping valid before last is a protocol violation; arbiter SHALL still hold grant until ready&last and forward oreq.valid=0 meanwhile.
REQ-019 Requests arriving simultaneously SHALL be resolved by the selection policy of REQ-024/REQ-025 in the same IDLE cycle.
REQ-020 SHALL keep a priority pointer ptr (same width as idx); updated only on completion edge to (idx+1) mod NUM_INPUTS, wrapping from NUM_INPUTS-1 to 0.

Reset
REQ-021 On resetn=0, asynchronously: state=IDLE, idx=0, ptr=0; oreq and all iresps SHALL read all-zero while reset asserted.
REQ-022 Reset asserted mid-burst SHALL abandon the transaction; after release, arbitration restarts from ptr=0 with no replay.
REQ-023 After reset release, first grant SHALL occur no earlier than the first edge at which resetn=1 is sampled.

Configuration
REQ-024 With macro CBUS_ARB_ROUND_ROBIN_EN defined, selection SHALL pick the first valid index searching ptr, ptr+1, ... wrapping modulo NUM_INPUTS.
REQ-025 Without CBUS_ARB_ROUND_ROBIN_EN, selection SHALL be fixed priority (lowest valid index wins); ptr SHALL be absent or unused, no other behaviour change.

Verification
REQ-026 Single master: NUM_INPUTS=2, ireqs[1] valid read addr 0x1fc0_0000 len=0, oresp ready&last on 3rd BUSY cycle -> grant idx=1 one cycle after valid, iresps[1].data=oresp.data, IDLE on next edge.
REQ-027 Burst: ireqs[0] valid len=3, ready every cycle with last on beat 4 -> 4 beats forwarded to iresps[0], no grant change, ireqs[1] pending served after 1 IDLE cycle.
REQ-028 Contention (RR defined): both masters valid continuously, 1-beat responses -> grants alternate 0,1,0,1; each transaction 3 cycles (IDLE+2 BUSY with ready on second).
REQ-029 Contention (RR undefined): same stimulus -> master 0 granted every transaction, master 1 never granted while master 0 valid.
REQ-030 Reset mid-burst: resetn low during beat 2 of len=3 burst -> oreq/iresps zero immediately (before next edge), state IDLE, ptr=0 after release; NUM_INPUTS=3 wrap: completion at idx=2 -> ptr=0.
